string_hw_avalon_master: RTL

Avalon-MM initiator that drives the String HW accelerator's four-register slave on behalf of a local requester. It accepts one string command (A, B, index, length) through a valid/ready port, then writes A, B and Control (go=1). It polls Control until done, reads Result and returns it through a valid/ready response port. It sits between a sequencing client (custom logic or a Nios II-side bridge) and the accelerator slave, so software no longer spins on the done bit.

---
 rtl/strhw_pkg.sv | 45 ++++
 rtl/string_hw_avalon_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strhw_pkg.sv
// strhw_pkg: register map, Control-register bit positions and FSM state type
// shared by the String HW accelerator initiator and anything that talks to the
// same four-register slave.
//
// Build option: STRHW_MASTER_TIMEOUT_EN adds the CLR state used to abandon a
// command whose done bit never appears.
package strhw_pkg;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;

  localparam int DONE_BIT   = 0;
  localparam int GO_BIT     = 1;
  localparam int INDEX_LSB  = 2;
  localparam int LENGTH_LSB = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_CTRL,
    ST_GAP,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_RES_RD,
    ST_RES_WAIT,
`ifdef STRHW_MASTER_TIMEOUT_EN
    ST_CLR,
`endif
    ST_RSP
  } state_t;

  // Control word that starts an operation: go=1, done=0, index and length packed.
  function automatic logic [31:0] ctrl_go_word(input logic [2:0] index, input logic [2:0] length);
    logic [31:0] w;
    w = '0;
    w[GO_BIT] = 1'b1;
    w[INDEX_LSB +: 3] = index;
    w[LENGTH_LSB +: 3] = length;
    return w;
  endfunction

endpackage

// File: rtl/string_hw_avalon_master.sv
// string_hw_avalon_master: Avalon-MM initiator that runs one String HW
// accelerator command per request. It writes A, B and Control (go=1), waits
// POLL_GAP cycles, polls Control until done, reads Result and hands it back on
// a valid/ready response port.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_a, cmd_b                  string operands
//   cmd_index, cmd_length         packed into Control[4:2] / Control[7:5]
//   rsp_valid/rsp_ready           response handshake, payload held until taken
//   rsp_result, rsp_error         Result value, poll-timeout flag
//   avm_*                         Avalon-MM master to the accelerator slave
//
// Parameters
//   POLL_GAP   idle cycles between the Control write and the first poll
//   MAX_POLLS  poll reads before giving up (timeout build only)
//
// Build option: STRHW_MASTER_TIMEOUT_EN compiles in a 10-bit poll counter and
// the CLR state; without it polling is unbounded and rsp_error is tied low.
//
// States
//   IDLE      | waiting for a command, cmd_ready=1
//   WR_A      | write operand A
//   WR_B      | write operand B
//   WR_CTRL   | write Control with go=1
//   GAP       | let a stale done bit clear before polling
//   POLL_RD   | read Control
//   POLL_WAIT | readdata valid, test done
//   RES_RD    | read Result (clears go in the slave)
//   RES_WAIT  | readdata valid, capture Result
//   CLR       | write Control=0 after a poll timeout
//   RSP       | response presented until accepted
module string_hw_avalon_master
  import strhw_pkg::*;
#(
  parameter int POLL_GAP  = 2,
  parameter int MAX_POLLS = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_index,
  input  logic [2:0]  cmd_length,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  if (POLL_GAP < 0 || MAX_POLLS < 1 || MAX_POLLS > 1024) begin : g_bad_params
    $error("string_hw_avalon_master: need POLL_GAP >= 0 and MAX_POLLS in 1..1024");
  end

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t state, next_state;

  logic [31:0]      cmd_b_q;
  logic [2:0]       cmd_index_q;
  logic [2:0]       cmd_length_q;
  logic [GAP_W-1:0] gap_cnt;

  logic [2:0]  address_d;
  logic [31:0] writedata_d;
  logic        write_d;
  logic        read_d;
  logic        chipselect_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_result_d;

`ifdef STRHW_MASTER_TIMEOUT_EN
  localparam logic [9:0] POLL_LAST = 10'(MAX_POLLS - 1);
  logic [9:0] poll_cnt;
  logic       rsp_error_q;
  logic       rsp_error_d;
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);

  // State, command latch, GAP down-counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cmd_b_q        <= '0;
      cmd_index_q    <= '0;
      cmd_length_q   <= '0;
      gap_cnt        <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_chipselect <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
    end else begin
      state          <= next_state;
      avm_address    <= address_d;
      avm_writedata  <= writedata_d;
      avm_write      <= write_d;
      avm_read       <= read_d;
      avm_chipselect <= chipselect_d;
      rsp_valid      <= rsp_valid_d;
      rsp_result     <= rsp_result_d;
      if (cmd_valid && cmd_ready) begin
        cmd_b_q      <= cmd_b;
        cmd_index_q  <= cmd_index;
        cmd_length_q <= cmd_length;
      end
      if (state == ST_WR_CTRL) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef STRHW_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt    <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_error_q <= rsp_error_d;
      if (state == ST_IDLE) begin
        poll_cnt <= '0;
      end else if (state == ST_POLL_WAIT && !avm_readdata[DONE_BIT]) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (cmd_valid) next_state = ST_WR_A;
      ST_WR_A:      next_state = ST_WR_B;
      ST_WR_B:      next_state = ST_WR_CTRL;
      ST_WR_CTRL:   next_state = (POLL_GAP == 0) ? ST_POLL_RD : ST_GAP;
      ST_GAP:       if (gap_cnt == '0) next_state = ST_POLL_RD;
      ST_POLL_RD:   next_state = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (avm_readdata[DONE_BIT]) begin
          next_state = ST_RES_RD;
`ifdef STRHW_MASTER_TIMEOUT_EN
        end else if (poll_cnt == POLL_LAST) begin
          next_state = ST_CLR;
`endif
        end else begin
          next_state = ST_POLL_RD;
        end
      end
      ST_RES_RD:    next_state = ST_RES_WAIT;
      ST_RES_WAIT:  next_state = ST_RSP;
`ifdef STRHW_MASTER_TIMEOUT_EN
      ST_CLR:       next_state = ST_RSP;
`endif
      ST_RSP:       if (rsp_ready) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so each bus state
  // drives the bus during exactly the cycle it occupies.
  always_comb begin
    address_d    = avm_address;
    writedata_d  = avm_writedata;
    write_d      = 1'b0;
    read_d       = 1'b0;
    chipselect_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result;
`ifdef STRHW_MASTER_TIMEOUT_EN
    rsp_error_d  = rsp_error_q;
`endif
    case (next_state)
      ST_WR_A: begin
        // Only reachable from IDLE, so the operand is still on the command port.
        chipselect_d = 1'b1;
        write_d      = 1'b1;
        address_d    = ADDR_A;
        writedata_d  = cmd_a;
      end
      ST_WR_B: begin
        chipselect_d = 1'b1;
        write_d      = 1'b1;
        address_d    = ADDR_B;
        writedata_d  = cmd_b_q;
      end
      ST_WR_CTRL: begin
        chipselect_d = 1'b1;
        write_d      = 1'b1;
        address_d    = ADDR_CTRL;
        writedata_d  = ctrl_go_word(cmd_index_q, cmd_length_q);
      end
      ST_POLL_RD: begin
        chipselect_d = 1'b1;
        read_d       = 1'b1;
        address_d    = ADDR_CTRL;
      end
      ST_RES_RD: begin
        chipselect_d = 1'b1;
        read_d       = 1'b1;
        address_d    = ADDR_RESULT;
      end
`ifdef STRHW_MASTER_TIMEOUT_EN
      ST_CLR: begin
        chipselect_d = 1'b1;
        write_d      = 1'b1;
        address_d    = ADDR_CTRL;
        writedata_d  = '0;
      end
`endif
      ST_RSP: begin
        rsp_valid_d = 1'b1;
        if (state == ST_RES_WAIT) begin
          rsp_result_d = avm_readdata;
`ifdef STRHW_MASTER_TIMEOUT_EN
          rsp_error_d  = 1'b0;
        end else if (state == ST_CLR) begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule
